data_mem_seq: RTL and testbench
===============================

# data_mem_seq

Parametrised successor to the single-port data memory. It is a 2^A-deep, W-bit data memory behind a valid/ready request port with registered (1-cycle) read responses. Initialisation is done by a sequential engine, one word per cycle, that replaces the single-cycle bulk reset write. It sits between the CPU load/store stage and the data array and reports `Busy` while initialising.

## Interface
- `W`, default 8: data word width, ≥1.
- `A`, default 8: address width; depth = 2^A, A ≥ 1.
- `INIT_MODE`, default 1: 0 = fill with zeros; 1 = fill `Core[i] = i`, zero-extended or truncated to W bits.

- `Clk` input 1: single clock, all state on rising edge.
- `ResetN` input 1: reset, synchronous and active-low.
- `Init` input 1: request to re-run initialisation; sampled only in IDLE.
- `ReqValid` input 1: request present.
- `ReqReady` output 1: request accepted this cycle when `ReqValid & ReqReady`.
- `ReqWrite` input 1: 1 = write, 0 = read.
- `ReqAddr` input A: word address.
- `ReqData` input W: write data.
- `RspValid` output 1: one-cycle pulse, response data valid.
- `RspData` output W: response data; holds its last value between pulses.
- `Busy` output 1: initialisation in progress.

## Operation
- The FSM has two states: INIT and IDLE. It also has an A-bit fill counter `Cnt`.
- **Reset** (`ResetN`=0 at an edge):
  - state ← INIT, `Cnt` ← 0.
  - `RspValid` ← 0, `RspData` ← 0.
  - Memory contents are unchanged by reset itself; the INIT state rewrites them.
- **INIT**:
  - Each cycle writes the fill pattern to `Core[Cnt]` and increments `Cnt`.
  - When `Cnt` = 2^A−1 is written, go to IDLE; `Cnt` wraps to 0.
  - `Busy`=1 and `ReqReady`=0 throughout INIT; `Init` is ignored.
- **IDLE**:
  - `Busy`=0.
  - `ReqReady` = !`Init`, combinational.
  - If `Init`=1: go to INIT with `Cnt` ← 0. No request is accepted that cycle.
- **Accepted read**:
  - Next cycle: `RspValid`=1 and `RspData` = `Core[ReqAddr]` as sampled at acceptance.
- **Accepted write**:
  - `Core[ReqAddr]` ← `ReqData` at that edge.
  - No response, unless the configuration macro below is defined.
- At most one request is accepted per cycle. Back-to-back accepted requests give back-to-back responses.
- **Read-after-write**: a read accepted the cycle after a write to the same address returns the new data.
- **Responses in flight**: a response for a request accepted in the cycle before `Init` or before entry to INIT is still delivered. `RspValid` is not suppressed by the state change.
- **Reset mid-INIT**: restarts at `Cnt` = 0. Reset also drops any pending response: `RspValid`=0 in the cycle after reset.

## Timing
- Read latency is 1 cycle, from the accepting edge to `RspValid` high.
- `ReqReady` has a combinational dependency on state and `Init` only, never on `ReqValid`.
- INIT lasts exactly 2^A cycles. With the defaults, `Busy` is high for 256 cycles after `ResetN` deasserts.
- The first request can be accepted in the cycle after the last fill write.
- All outputs except `ReqReady` are registered.
- Output values in the cycle after reset:
  - `Busy`=1, `ReqReady`=0.
  - `RspValid`=0, `RspData`=0.

## Configuration
- Macro `DMEM_WRITE_RESP_EN`.
- Defined: an accepted write also produces a response.
  - `RspValid`=1 one cycle later, with `RspData` = the written `ReqData`.
  - This lets the pipeline count store completions.
- Undefined: writes produce no response; `RspValid` pulses for reads only.

## Test plan
- **Reset fill**, defaults: pulse `ResetN` low for 1 cycle.
  - `Busy` is high for exactly 256 cycles and `ReqReady` is 0 during that time.
  - Then read addresses 0x00, 0x7F and 0xFF. Responses must be 0x00, 0x7F and 0xFF, one cycle after each accept.
- **Write/read pipeline**: write 0xA5 to 0x10, then read 0x10 on the next cycle.
  - `RspData`=0xA5 with `RspValid` high on the cycle after the read.
  - Without the macro, no `RspValid` for the write.
- **Back-to-back reads**: read 0x03, 0x04, 0x05 on consecutive cycles.
  - `RspValid` is high 3 consecutive cycles with data 0x03, 0x04, 0x05.
  - `RspData` holds 0x05 afterwards.
- **Init collision**: in IDLE, assert `Init` and `ReqValid` (write 0x55 to 0x20) in the same cycle.
  - `ReqReady`=0 and the write is dropped.
  - `Busy` goes high for 256 cycles, after which a read of 0x20 returns 0x20.
- **Reset mid-INIT**: assert `ResetN`=0 at fill cycle 100.
  - `Busy` restarts and stays high for a full 256 cycles from release.
  - A read of 0x64 returns 0x64.
- **`DMEM_WRITE_RESP_EN` defined**: write 0x3C to 0x01.
  - `RspValid`=1 with `RspData`=0x3C next cycle.
  - Read 0x01 returns 0x3C.

Source files
------------

// File: rtl/data_mem_seq.sv
// 2^A x W data memory with a valid/ready request port, 1-cycle read responses
// and a one-word-per-cycle init engine. Optional macro: DMEM_WRITE_RESP_EN.
module data_mem_seq #(
    parameter int unsigned W         = 8,
    parameter int unsigned A         = 8,
    parameter int unsigned INIT_MODE = 1
) (
    input  logic         Clk,
    input  logic         ResetN,
    input  logic         Init,
    input  logic         ReqValid,
    output logic         ReqReady,
    input  logic         ReqWrite,
    input  logic [A-1:0] ReqAddr,
    input  logic [W-1:0] ReqData,
    output logic         RspValid,
    output logic [W-1:0] RspData,
    output logic         Busy
);

    localparam int unsigned DEPTH = 1 << A;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t       state, state_nxt;
    logic [A-1:0] cnt, cnt_nxt;
    logic [W-1:0] core [DEPTH];

    logic         accept;
    logic         we;
    logic [A-1:0] waddr;
    logic [W-1:0] wdata;
    logic [W-1:0] fill_word;

    assign fill_word = (INIT_MODE == 1) ? W'(cnt) : '0;
    assign Busy      = (state == ST_INIT);

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The single write port is shared: the fill engine owns it in INIT,
    // accepted stores own it in IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ReqReady  = 1'b0;
        accept    = 1'b0;
        we        = 1'b0;
        waddr     = ReqAddr;
        wdata     = ReqData;
        case (state)
            ST_INIT: begin
                we      = 1'b1;
                waddr   = cnt;
                wdata   = fill_word;
                cnt_nxt = cnt + A'(1);
                if (cnt == '1) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ReqReady = !Init;
                accept   = ReqValid && !Init;
                we       = accept && ReqWrite;
                if (Init) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (ResetN && we) begin
            core[waddr] <= wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            RspValid <= 1'b0;
            RspData  <= '0;
        end else begin
`ifdef DMEM_WRITE_RESP_EN
            RspValid <= accept;
            if (accept) begin
                RspData <= ReqWrite ? ReqData : core[ReqAddr];
            end
`else
            RspValid <= accept && !ReqWrite;
            if (accept && !ReqWrite) begin
                RspData <= core[ReqAddr];
            end
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_seq.sv
// Self-checking bench for data_mem_seq: directed scenarios followed by random
// traffic, compared every cycle against an array-based reference model.
module tb_data_mem_seq;

    localparam int DEPTH = 256;
`ifdef DMEM_WRITE_RESP_EN
    localparam bit WR_RESP = 1'b1;
`else
    localparam bit WR_RESP = 1'b0;
`endif

    logic       Clk      = 1'b0;
    logic       ResetN   = 1'b1;
    logic       Init     = 1'b0;
    logic       ReqValid = 1'b0;
    logic       ReqWrite = 1'b0;
    logic [7:0] ReqAddr  = '0;
    logic [7:0] ReqData  = '0;
    logic       ReqReady;
    logic       RspValid;
    logic [7:0] RspData;
    logic       Busy;

    always #5 Clk = ~Clk;

    data_mem_seq #(
        .W         (8),
        .A         (8),
        .INIT_MODE (1)
    ) dut (
        .Clk      (Clk),
        .ResetN   (ResetN),
        .Init     (Init),
        .ReqValid (ReqValid),
        .ReqReady (ReqReady),
        .ReqWrite (ReqWrite),
        .ReqAddr  (ReqAddr),
        .ReqData  (ReqData),
        .RspValid (RspValid),
        .RspData  (RspData),
        .Busy     (Busy)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: memory image, remaining busy cycles, expected response.
    logic [7:0] m_mem [DEPTH];
    int         m_busy_left = 0;
    logic       m_rsp_valid = 1'b0;
    logic [7:0] m_rsp_data  = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
    endtask

    // No access is possible while busy, so the whole fill can be modelled at once.
    function automatic void model_fill();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'(i);
        m_busy_left = DEPTH;
    endfunction

    task automatic cycle(input logic init, input logic valid, input logic write,
                         input logic [7:0] addr, input logic [7:0] data);
        logic exp_ready;
        logic acc;
        @(negedge Clk);
        Init     = init;
        ReqValid = valid;
        ReqWrite = write;
        ReqAddr  = addr;
        ReqData  = data;
        #1;
        exp_ready = (m_busy_left == 0) && !init;
        check_eq("busy",      32'(Busy),     32'(m_busy_left > 0));
        check_eq("ready",     32'(ReqReady), 32'(exp_ready));
        check_eq("rsp_valid", 32'(RspValid), 32'(m_rsp_valid));
        check_eq("rsp_data",  32'(RspData),  32'(m_rsp_data));
        acc = valid && exp_ready;
        m_rsp_valid = acc && (!write || WR_RESP);
        if (m_rsp_valid) m_rsp_data = write ? data : m_mem[addr];
        if (acc && write) m_mem[addr] = data;
        if (m_busy_left > 0) m_busy_left--;
        else if (init) model_fill();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic rd(input logic [7:0] addr);
        cycle(1'b0, 1'b1, 1'b0, addr, 8'h00);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        cycle(1'b0, 1'b1, 1'b1, addr, data);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        ResetN   = 1'b0;
        Init     = 1'b0;
        ReqValid = 1'b0;
        ReqWrite = 1'b0;
        @(posedge Clk);
        #1;
        ResetN = 1'b1;
        model_fill();
        m_rsp_valid = 1'b0;
        m_rsp_data  = '0;
    endtask

    logic       r_init;
    logic       r_valid;
    logic       r_write;
    logic [7:0] r_addr;
    logic [7:0] r_data;

    initial begin
        // Reset fill and first reads
        do_reset();
        repeat (DEPTH) idle();
        rd(8'h00);
        rd(8'h7F);
        rd(8'hFF);
        idle();
        idle();

        // Write then read-after-write
        wr(8'h10, 8'hA5);
        rd(8'h10);
        idle();
        idle();

        // Back-to-back reads, data holds afterwards
        rd(8'h03);
        rd(8'h04);
        rd(8'h05);
        idle();
        idle();

        // Read in flight across Init, colliding write is dropped
        rd(8'h10);
        cycle(1'b1, 1'b1, 1'b1, 8'h20, 8'h55);
        repeat (DEPTH) idle();
        rd(8'h20);
        rd(8'h10);
        idle();

        // Reset at fill cycle 100
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (100) idle();
        do_reset();
        repeat (DEPTH) idle();
        rd(8'h64);
        idle();

        // Store followed by load of the same word
        wr(8'h01, 8'h3C);
        rd(8'h01);
        idle();
        idle();

        // Random traffic with a small hot address set for read-after-write hits
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                r_init  = ($urandom_range(0, 299) == 0);
                r_valid = ($urandom_range(0, 3) != 0);
                r_write = ($urandom_range(0, 1) == 1);
                r_addr  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
                r_data  = 8'($urandom);
                cycle(r_init, r_valid, r_write, r_addr, r_data);
            end
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "time limit");
    end

endmodule
